// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit owning the HI/LO pair.
// Shift-add multiply and restoring divide, one bit per clock.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             divzero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] acc;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic               last;

   // acc = {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, opnd} : '0);
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = acc[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opnd};
      if (div_diff[WIDTH])
         div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      last = (cnt == CW'(WIDTH - 1));
   end

   assign busy = (state == MUL) || (state == DIV);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         opnd    <= '0;
         acc     <= '0;
         hi      <= '0;
         lo      <= '0;
         divzero <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  unique case (op)
                     2'b00: begin
                        opnd  <= a;
                        acc   <= {{WIDTH{1'b0}}, b};
                        cnt   <= '0;
                        state <= MUL;
                     end
                     2'b01: begin
                        if (b == '0) begin
                           hi      <= a;
                           lo      <= '1;
                           divzero <= 1'b1;
                           state   <= DONE;
                        end else begin
                           opnd  <= b;
                           acc   <= {{WIDTH{1'b0}}, a};
                           cnt   <= '0;
                           state <= DIV;
                        end
                     end
                     2'b10: hi <= a;
                     2'b11: lo <= a;
                  endcase
               end
            end
            MUL: begin
               acc <= mul_next;
               cnt <= cnt + 1'b1;
               if (last) begin
                  hi      <= mul_next[2*WIDTH-1:WIDTH];
                  lo      <= mul_next[WIDTH-1:0];
                  divzero <= 1'b0;
                  state   <= DONE;
               end
            end
            DIV: begin
               acc <= div_next;
               cnt <= cnt + 1'b1;
               if (last) begin
                  hi      <= div_next[2*WIDTH-1:WIDTH];
                  lo      <= div_next[WIDTH-1:0];
                  divzero <= 1'b0;
                  state   <= DONE;
               end
            end
            DONE: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed table, corner sequences and
// random operations checked against an arithmetic reference model.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic         divzero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [W-1:0] hi_m;
   logic [W-1:0] lo_m;
   logic         dz_m;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } vec_t;

   vec_t tbl[7];

   muldiv_unit #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .divzero (divzero),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%h required=%h", nm, act, exp);
   endtask

   task automatic model(input logic [1:0] o, input logic [W-1:0] ai,
                        input logic [W-1:0] bi, output logic [W-1:0] eh,
                        output logic [W-1:0] el, output logic ed);
      logic [2*W-1:0] p;
      eh = hi_m;
      el = lo_m;
      ed = dz_m;
      case (o)
         2'b00: begin
            p  = {{W{1'b0}}, ai} * {{W{1'b0}}, bi};
            eh = p[2*W-1:W];
            el = p[W-1:0];
            ed = 1'b0;
         end
         2'b01: begin
            if (bi == 0) begin
               eh = ai;
               el = '1;
               ed = 1'b1;
            end else begin
               eh = ai % bi;
               el = ai / bi;
               ed = 1'b0;
            end
         end
         2'b10: eh = ai;
         default: el = ai;
      endcase
   endtask

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] ai,
                         input logic [W-1:0] bi, input logic [W-1:0] eh,
                         input logic [W-1:0] el, input logic ed,
                         input string nm);
      int lat;
      int nb;
      int exp_lat;
      bit held;
      bit is_mt;
      is_mt   = o[1];
      exp_lat = (o == 2'b01 && bi == 0) ? 0 : W;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = ai;
      b     = bi;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      lat   = 0;
      nb    = 0;
      held  = 1'b1;
      if (is_mt) begin
         check({nm, "_mt_busy"}, 64'(busy), 64'd0);
         check({nm, "_mt_done"}, 64'(done), 64'd0);
      end else begin
         while (!done && lat < W + 10) begin
            if (busy) nb++;
            if (hi !== hi_m || lo !== lo_m) held = 1'b0;
            @(posedge clk);
            #1;
            lat++;
         end
         check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
         check({nm, "_busy_cycles"}, 64'(nb), 64'(exp_lat));
         check({nm, "_hold"}, 64'(held), 64'd1);
      end
      check({nm, "_hi"}, 64'(hi), 64'(eh));
      check({nm, "_lo"}, 64'(lo), 64'(el));
      check({nm, "_divzero"}, 64'(divzero), 64'(ed));
      if (!is_mt) begin
         @(posedge clk);
         #1;
         check({nm, "_done_pulse"}, 64'({done, busy}), 64'd0);
      end
      hi_m = eh;
      lo_m = el;
      dz_m = ed;
   endtask

   initial begin
      logic [1:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] eh;
      logic [W-1:0] el;
      logic         ed;
      int           lat;
      bit           held;

      tbl[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      tbl[1] = '{2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
      tbl[2] = '{2'b01, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0};
      tbl[3] = '{2'b01, 32'h1234_5678, 32'd0,
                 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
      tbl[4] = '{2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0};
      tbl[5] = '{2'b10, 32'hDEAD_BEEF, 32'd0,
                 32'hDEAD_BEEF, 32'd12, 1'b0};
      tbl[6] = '{2'b11, 32'h0000_CAFE, 32'd0,
                 32'hDEAD_BEEF, 32'h0000_CAFE, 1'b0};

      reset = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      hi_m  = '0;
      lo_m  = '0;
      dz_m  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {busy, done, divzero, hi, lo}, '0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 7; i++)
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo,
                tbl[i].dz, $sformatf("vec%0d", i));

      // MULTU 6*7 with MTHI/MTLO requests held during busy
      @(negedge clk);
      start = 1'b1;
      op    = 2'b00;
      a     = 32'd6;
      b     = 32'd7;
      @(posedge clk);
      #1;
      op    = 2'b10;
      a     = 32'hFFFF_FFFF;
      lat   = 0;
      held  = 1'b1;
      while (!done && lat < W + 10) begin
         if (lat == 3) op = 2'b11;
         if (lat == 6) start = 1'b0;
         if (hi !== hi_m || lo !== lo_m) held = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
      check("ign_latency", 64'(lat), 64'(W));
      check("ign_hold", 64'(held), 64'd1);
      check("ign_result", {hi, lo}, 64'd42);
      @(posedge clk);
      #1;
      check("ign_after", {hi, lo, 1'b0, done}, {64'd42, 2'b00});
      hi_m = '0;
      lo_m = 32'd42;
      dz_m = 1'b0;

      // asynchronous reset in the middle of a MULTU
      @(negedge clk);
      start = 1'b1;
      op    = 2'b00;
      a     = 32'h0001_2345;
      b     = 32'h0006_789A;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("rst_async", {busy, done, divzero, hi, lo}, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      hi_m  = '0;
      lo_m  = '0;
      dz_m  = 1'b0;
      run_op(2'b01, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, "post_rst");

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 5) == 0) rb = '0;
         else if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 20);
         model(ro, ra, rb, eh, el, ed);
         run_op(ro, ra, rb, eh, el, ed, $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
